// File: rtl/fifo_gen2_pkg.sv
// ---------------------------------------------------------------------------
// fifo_gen2_pkg
// Shared definitions for the second-generation synchronous FIFO.
//   DEF_WIDTH / DEF_BIT_DEPTH : default word width and log2 depth
//   word_t / level_t          : data word and fill-level types at the defaults
//   ERR_OVF / ERR_UDF         : bit positions inside err_cause
//   sat_thresh()              : clamps a threshold value to the FIFO depth
// ---------------------------------------------------------------------------
package fifo_gen2_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_BIT_DEPTH = 4;

  typedef logic [DEF_WIDTH-1:0] word_t;
  typedef logic [DEF_BIT_DEPTH:0] level_t;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  // A threshold above the depth could never be reached by fill_level, so
  // larger values are pinned to the depth itself.
  function automatic int unsigned sat_thresh(input int unsigned value,
                                             input int unsigned depth);
    if (value > depth)
      return depth;
    else
      return value;
  endfunction

endpackage

// File: rtl/fifo_gen2_mem.sv
// ---------------------------------------------------------------------------
// fifo_gen2_mem
// Storage array for fifo_sync_gen2: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
//   clk     : write clock, rising edge
//   wr_en   : write strobe
//   wr_addr : write address (BIT_DEPTH bits)
//   wr_data : write data (WIDTH bits)
//   rd_addr : read address (BIT_DEPTH bits)
//   rd_data : read data, follows rd_addr combinationally
// ---------------------------------------------------------------------------
module fifo_gen2_mem
  import fifo_gen2_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BIT_DEPTH = DEF_BIT_DEPTH
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [BIT_DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [BIT_DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  localparam int DEPTH = 2 ** BIT_DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_gen2.sv
// ---------------------------------------------------------------------------
// fifo_sync_gen2
// Parametrised single-clock first-word-fall-through FIFO with a true full
// condition at DEPTH entries, explicit fill level, runtime-programmable
// almost thresholds, a registered error pulse with cause bits and an
// optional high-water mark.
//
// Optional feature: define FIFO_PEAK_LEVEL_EN to build the peak_level
// register; otherwise peak_level is tied to 0 and peak_clr is ignored.
//
// Ports:
//   clk, reset         : clock (rising edge), async active-high reset
//   push, data_in      : write request and data
//   pop                : read request
//   data_out           : head word, 0 while empty
//   full, almost_full  : level == DEPTH, level >= af threshold
//   empty, almost_empty: level == 0,     level <= ae threshold
//   fill_level         : entry count 0..DEPTH
//   af_thresh_in/_wr   : load a new almost_full threshold
//   ae_thresh_in/_wr   : load a new almost_empty threshold
//   error, err_cause   : illegal access in previous cycle (bit0 ovf, bit1 udf)
//   peak_level         : high-water mark
//   peak_clr           : reload high-water mark from current level
// ---------------------------------------------------------------------------
module fifo_sync_gen2
  import fifo_gen2_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BIT_DEPTH = 4,
  parameter int AF_RESET  = 12,
  parameter int AE_RESET  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 pop,
  output logic [WIDTH-1:0]     data_out,
  output logic                 full,
  output logic                 almost_full,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [BIT_DEPTH:0]   fill_level,
  input  logic [BIT_DEPTH:0]   af_thresh_in,
  input  logic                 af_thresh_wr,
  input  logic [BIT_DEPTH:0]   ae_thresh_in,
  input  logic                 ae_thresh_wr,
  output logic                 error,
  output logic [1:0]           err_cause,
  output logic [BIT_DEPTH:0]   peak_level,
  input  logic                 peak_clr
);

  localparam int unsigned DEPTH = 2 ** BIT_DEPTH;
  localparam int LW = BIT_DEPTH + 1;

  localparam logic [BIT_DEPTH:0]   DEPTH_L   = LW'(DEPTH);
  localparam logic [BIT_DEPTH:0]   LEVEL_ONE = LW'(1);
  localparam logic [BIT_DEPTH-1:0] PTR_ONE   = BIT_DEPTH'(1);
  localparam logic [BIT_DEPTH:0]   AF_INIT   = LW'(sat_thresh($unsigned(AF_RESET), DEPTH));
  localparam logic [BIT_DEPTH:0]   AE_INIT   = LW'(sat_thresh($unsigned(AE_RESET), DEPTH));

  logic [BIT_DEPTH-1:0] wr_ptr;
  logic [BIT_DEPTH-1:0] rd_ptr;
  logic [BIT_DEPTH:0]   level_next;
  logic [BIT_DEPTH:0]   af_thresh;
  logic [BIT_DEPTH:0]   ae_thresh;
  logic [WIDTH-1:0]     rd_data;
  logic [1:0]           err_next;
  logic                 push_ok;
  logic                 pop_ok;

  // A push into a full FIFO is still legal when a pop frees a slot in the
  // same cycle; a pop is only ever legal when something is stored.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  fifo_gen2_mem #(
    .WIDTH     (WIDTH),
    .BIT_DEPTH (BIT_DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign data_out = empty ? '0 : rd_data;

  // Flags come only from registered level and thresholds, so they change
  // cleanly once per clock.
  assign full         = (fill_level == DEPTH_L);
  assign empty        = (fill_level == '0);
  assign almost_full  = (fill_level >= af_thresh);
  assign almost_empty = (fill_level <= ae_thresh);

  always_comb begin
    level_next = fill_level;
    if (push_ok && !pop_ok)
      level_next = fill_level + LEVEL_ONE;
    else if (pop_ok && !push_ok)
      level_next = fill_level - LEVEL_ONE;
  end

  // Pointers wrap naturally at DEPTH; the separate level counter resolves
  // the full/empty ambiguity when they are equal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_ONE;
      fill_level <= level_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      af_thresh <= AF_INIT;
      ae_thresh <= AE_INIT;
    end else begin
      if (af_thresh_wr)
        af_thresh <= LW'(sat_thresh(32'(af_thresh_in), DEPTH));
      if (ae_thresh_wr)
        ae_thresh <= LW'(sat_thresh(32'(ae_thresh_in), DEPTH));
    end
  end

  always_comb begin
    err_next          = '0;
    err_next[ERR_OVF] = push && full && !pop;
    err_next[ERR_UDF] = pop && empty;
  end

  // error is a one-cycle pulse reporting the previous cycle's access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cause <= '0;
      error     <= 1'b0;
    end else begin
      err_cause <= err_next;
      error     <= |err_next;
    end
  end

`ifdef FIFO_PEAK_LEVEL_EN
  // Clear reloads the present level rather than zero so the mark never
  // reads below what is actually stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      peak_level <= '0;
    else if (peak_clr)
      peak_level <= fill_level;
    else if (level_next > peak_level)
      peak_level <= level_next;
  end
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_level      = '0;
`endif

endmodule

// File: tb/tb_fifo_sync_gen2.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_gen2
// Directed self-checking bench for fifo_sync_gen2 at default parameters
// (32-bit words, 16 entries, almost_full at 12, almost_empty at 4).
// ---------------------------------------------------------------------------
module tb_fifo_sync_gen2;

`ifdef FIFO_PEAK_LEVEL_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        push;
  logic [31:0] data_in;
  logic        pop;
  logic [31:0] data_out;
  logic        full;
  logic        almost_full;
  logic        empty;
  logic        almost_empty;
  logic [4:0]  fill_level;
  logic [4:0]  af_thresh_in;
  logic        af_thresh_wr;
  logic [4:0]  ae_thresh_in;
  logic        ae_thresh_wr;
  logic        error;
  logic [1:0]  err_cause;
  logic [4:0]  peak_level;
  logic        peak_clr;

  int checks = 0;
  int passed = 0;

  logic [31:0] q [$];

  fifo_sync_gen2 #(
    .WIDTH     (32),
    .BIT_DEPTH (4),
    .AF_RESET  (12),
    .AE_RESET  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .fill_level   (fill_level),
    .af_thresh_in (af_thresh_in),
    .af_thresh_wr (af_thresh_wr),
    .ae_thresh_in (ae_thresh_in),
    .ae_thresh_wr (ae_thresh_wr),
    .error        (error),
    .err_cause    (err_cause),
    .peak_level   (peak_level),
    .peak_clr     (peak_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic p, input logic [31:0] d, input logic r);
    push    = p;
    data_in = d;
    pop     = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " level"},  32'(fill_level), 32'd0);
    checkOutput({tag, " empty"},  32'(empty), 32'd1);
    checkOutput({tag, " aempty"}, 32'(almost_empty), 32'd1);
    checkOutput({tag, " full"},   32'(full), 32'd0);
    checkOutput({tag, " afull"},  32'(almost_full), 32'd0);
    checkOutput({tag, " error"},  32'(error), 32'd0);
    checkOutput({tag, " cause"},  32'(err_cause), 32'd0);
    checkOutput({tag, " dout"},   data_out, 32'd0);
    checkOutput({tag, " peak"},   32'(peak_level), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset        = 1'b1;
    push         = 1'b0;
    pop          = 1'b0;
    data_in      = '0;
    af_thresh_in = '0;
    af_thresh_wr = 1'b0;
    ae_thresh_in = '0;
    ae_thresh_wr = 1'b0;
    peak_clr     = 1'b0;

    tick();
    tick();
    checkResetState("reset");
    reset = 1'b0;

    // Fill to 16 with no pops.
    $display("[TB] fill to full");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h1000 + 32'(i), 1'b0);
      q.push_back(32'h1000 + 32'(i));
      tick();
      checkOutput($sformatf("fill%0d level", i), 32'(fill_level), 32'(i + 1));
      checkOutput($sformatf("fill%0d afull", i), 32'(almost_full), 32'(i + 1 >= 12));
      checkOutput($sformatf("fill%0d full", i), 32'(full), 32'(i + 1 == 16));
      checkOutput($sformatf("fill%0d aempty", i), 32'(almost_empty), 32'(i + 1 <= 4));
      checkOutput($sformatf("fill%0d dout", i), data_out, 32'h1000);
    end
    checkOutput("fill error", 32'(error), 32'd0);

    // Overflow: push into full FIFO without pop.
    applyStimulus(1'b1, 32'hDEAD, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("ovf error", 32'(error), 32'd1);
    checkOutput("ovf cause", 32'(err_cause), 32'b01);
    checkOutput("ovf level", 32'(fill_level), 32'd16);
    checkOutput("ovf dout", data_out, 32'h1000);
    tick();
    checkOutput("ovf pulse", 32'(error), 32'd0);
    checkOutput("ovf pulse cause", 32'(err_cause), 32'd0);

    // Push and pop together while full, 20 cycles, wrapping pointers.
    $display("[TB] streaming while full");
    for (int k = 0; k < 20; k++) begin
      checkOutput($sformatf("stream%0d head", k), data_out, q[0]);
      applyStimulus(1'b1, 32'h2000 + 32'(k), 1'b1);
      void'(q.pop_front());
      q.push_back(32'h2000 + 32'(k));
      tick();
      checkOutput($sformatf("stream%0d level", k), 32'(fill_level), 32'd16);
      checkOutput($sformatf("stream%0d error", k), 32'(error), 32'd0);
    end
    checkOutput("stream head after wrap", data_out, 32'h2004);

    // Drain completely, checking order.
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("drain%0d dout", k), data_out, q.pop_front());
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("drain level", 32'(fill_level), 32'd0);
    checkOutput("drain empty", 32'(empty), 32'd1);
    checkOutput("drain dout", data_out, 32'd0);
    checkOutput("drain error", 32'(error), 32'd0);

    // Underflow on empty, then simultaneous push/pop on empty.
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("udf error", 32'(error), 32'd1);
    checkOutput("udf cause", 32'(err_cause), 32'b10);
    checkOutput("udf level", 32'(fill_level), 32'd0);
    applyStimulus(1'b1, 32'h3333, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("pp empty level", 32'(fill_level), 32'd1);
    checkOutput("pp empty cause", 32'(err_cause), 32'b10);
    checkOutput("pp empty error", 32'(error), 32'd1);
    checkOutput("pp empty dout", data_out, 32'h3333);
    tick();
    checkOutput("pp empty pulse", 32'(error), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("pp drained", 32'(fill_level), 32'd0);

    // Programmable thresholds: af=5, ae=2.
    $display("[TB] programmable thresholds");
    af_thresh_in = 5'd5;
    ae_thresh_in = 5'd2;
    af_thresh_wr = 1'b1;
    ae_thresh_wr = 1'b1;
    tick();
    af_thresh_wr = 1'b0;
    ae_thresh_wr = 1'b0;
    checkOutput("thr0 afull", 32'(almost_full), 32'd0);
    checkOutput("thr0 aempty", 32'(almost_empty), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 32'h4000 + 32'(i), 1'b0);
      tick();
      checkOutput($sformatf("thr%0d afull", i), 32'(almost_full), 32'(i >= 5));
      checkOutput($sformatf("thr%0d aempty", i), 32'(almost_empty), 32'(i <= 2));
    end
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Writing 20 saturates to 16: almost_full only when full.
    af_thresh_in = 5'd20;
    af_thresh_wr = 1'b1;
    tick();
    af_thresh_wr = 1'b0;
    checkOutput("sat5 afull", 32'(almost_full), 32'd0);
    for (int i = 6; i <= 16; i++) begin
      applyStimulus(1'b1, 32'h5000 + 32'(i), 1'b0);
      tick();
      checkOutput($sformatf("sat%0d afull", i), 32'(almost_full), 32'(i == 16));
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("sat full", 32'(full), 32'd1);

    // Asynchronous reset with the FIFO full, no clock edge in between.
    #2;
    reset = 1'b1;
    #1;
    checkResetState("async reset full");
    tick();
    reset = 1'b0;
    #1;

    // High-water mark: fill to 9, drain to 3, clear.
    $display("[TB] peak level");
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 32'h6000 + 32'(i), 1'b0);
      tick();
      checkOutput($sformatf("pk fill%0d afull", i), 32'(almost_full), 32'd0);
      checkOutput($sformatf("pk fill%0d aempty", i), 32'(almost_empty), 32'(i <= 4));
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("pk level", 32'(fill_level), 32'd3);
    checkOutput("pk dout", data_out, 32'h6007);
    checkOutput("pk peak", 32'(peak_level), PEAK_ON ? 32'd9 : 32'd0);
    peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    checkOutput("pk clr", 32'(peak_level), PEAK_ON ? 32'd3 : 32'd0);
    applyStimulus(1'b1, 32'h7000, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("pk regrow", 32'(peak_level), PEAK_ON ? 32'd4 : 32'd0);

    // Reset asserted mid-fill while push is active.
    applyStimulus(1'b1, 32'h8000, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checkResetState("async reset midfill");
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    tick();
    checkResetState("post reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
